rast_line_stepper: RTL and testbench



---
 rtl/rast_pkg.sv | 33 +++
 rtl/rast_line_setup.sv | 38 +++
 rtl/rast_line_stepper.sv | 172 +++++++++++++++++
 tb/tb_rast_line_stepper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rast_pkg.sv
// Shared types for the line rasterizer: FSM state, octant encoding and line_in field offsets.
package rast_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_STEP  = 2'd2
  } state_t;

  typedef struct packed {
    logic steep;
    logic x_neg;
    logic y_neg;
  } octant_t;

  // line_in is packed {x0, y0, x1, y1, attr}; attr occupies the LSBs from bit 0.
  function automatic int y1_lsb(int aw);
    return aw;
  endfunction

  function automatic int x1_lsb(int cw, int aw);
    return aw + cw;
  endfunction

  function automatic int y0_lsb(int cw, int aw);
    return aw + 2 * cw;
  endfunction

  function automatic int x0_lsb(int cw, int aw);
    return aw + 3 * cw;
  endfunction

endpackage

// File: rtl/rast_line_setup.sv
// Combinational line setup: deltas, absolute values, octant and initial Bresenham error.
module rast_line_setup
  import rast_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]        x0,
  input  logic [COORD_W-1:0]        y0,
  input  logic [COORD_W-1:0]        x1,
  input  logic [COORD_W-1:0]        y1,
  output logic [COORD_W-1:0]        major,
  output logic [COORD_W-1:0]        minor,
  output octant_t                   oct,
  output logic signed [COORD_W+2:0] err_init
);

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic [COORD_W-1:0]      adx;
  logic [COORD_W-1:0]      ady;

  assign dx = $signed({1'b0, x1}) - $signed({1'b0, x0});
  assign dy = $signed({1'b0, y1}) - $signed({1'b0, y0});

  // The magnitude of a COORD_W+1 signed difference of unsigned coordinates always fits COORD_W bits.
  assign adx = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
  assign ady = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];

  assign oct.steep = ady > adx;
  assign oct.x_neg = dx[COORD_W];
  assign oct.y_neg = dy[COORD_W];

  assign major = oct.steep ? ady : adx;
  assign minor = oct.steep ? adx : ady;

  assign err_init = $signed({2'b00, minor, 1'b0}) - $signed({3'b000, major});

endmodule

// File: rtl/rast_line_stepper.sv
// Bresenham line stepper: latches one line, sets it up in one cycle, then emits one pixel per cycle.
// Optional screen clipping is enabled by defining RAST_CLIP_EN.
module rast_line_stepper
  import rast_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int ATTR_W   = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4*COORD_W+ATTR_W-1:0] line_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        abort,
  output logic [COORD_W-1:0]          pix_x,
  output logic [COORD_W-1:0]          pix_y,
  output logic [ATTR_W-1:0]           pix_attr,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        pix_last,
  output octant_t                     octant,
  output logic                        line_done,
  output logic                        busy,
  output state_t                      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the producer holds its
  // payload stable while valid && !ready, and valid never depends combinationally on ready.

`ifdef RAST_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam int X0_L = x0_lsb(COORD_W, ATTR_W);
  localparam int Y0_L = y0_lsb(COORD_W, ATTR_W);
  localparam int X1_L = x1_lsb(COORD_W, ATTR_W);
  localparam int Y1_L = y1_lsb(ATTR_W);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  state_t                      state;
  logic [4*COORD_W+ATTR_W-1:0] line_q;
  logic signed [COORD_W+2:0]   err;
  logic signed [COORD_W+2:0]   major2;
  logic signed [COORD_W+2:0]   minor2;
  logic [COORD_W-1:0]          remaining;

  logic [COORD_W-1:0]        s_x0, s_y0, s_x1, s_y1;
  logic [COORD_W-1:0]        s_major, s_minor;
  octant_t                   s_oct;
  logic signed [COORD_W+2:0] s_err;

  logic [COORD_W-1:0]        nx, ny;
  logic signed [COORD_W+2:0] ne;
  logic                      adv;
  logic                      vis_first;
  logic                      vis_next;

  function automatic logic on_screen(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return !CLIP_EN || ((32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H)));
  endfunction

  assign s_x0 = line_q[X0_L +: COORD_W];
  assign s_y0 = line_q[Y0_L +: COORD_W];
  assign s_x1 = line_q[X1_L +: COORD_W];
  assign s_y1 = line_q[Y1_L +: COORD_W];

  rast_line_setup #(.COORD_W(COORD_W)) u_setup (
    .x0       (s_x0),
    .y0       (s_y0),
    .x1       (s_x1),
    .y1       (s_y1),
    .major    (s_major),
    .minor    (s_minor),
    .oct      (s_oct),
    .err_init (s_err)
  );

  always_comb begin
    nx = pix_x;
    ny = pix_y;
    ne = err;
    if (octant.steep) ny = octant.y_neg ? pix_y - ONE : pix_y + ONE;
    else              nx = octant.x_neg ? pix_x - ONE : pix_x + ONE;
    if (!err[COORD_W+2] && (err != '0)) begin
      if (octant.steep) nx = octant.x_neg ? pix_x - ONE : pix_x + ONE;
      else              ny = octant.y_neg ? pix_y - ONE : pix_y + ONE;
      ne = err - major2;
    end
    ne = ne + minor2;
  end

  // Hidden (clipped) pixels advance on their own; pix_valid is always high in STEP otherwise.
  assign adv       = !pix_valid || pix_ready;
  assign vis_first = on_screen(s_x0, s_y0);
  assign vis_next  = on_screen(nx, ny);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      line_done <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_attr  <= '0;
      octant    <= '0;
      line_q    <= '0;
      err       <= '0;
      major2    <= '0;
      minor2    <= '0;
      remaining <= '0;
    end else begin
      line_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            line_q   <= line_in;
            state    <= ST_SETUP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (abort) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            line_done <= 1'b1;
          end else begin
            pix_x     <= s_x0;
            pix_y     <= s_y0;
            pix_attr  <= line_q[ATTR_W-1:0];
            octant    <= s_oct;
            err       <= s_err;
            major2    <= $signed({2'b00, s_major, 1'b0});
            minor2    <= $signed({2'b00, s_minor, 1'b0});
            remaining <= s_major;
            pix_valid <= vis_first;
            pix_last  <= (s_major == '0) && vis_first;
            state     <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (abort || (adv && remaining == '0)) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            line_done <= 1'b1;
          end else if (adv) begin
            pix_x     <= nx;
            pix_y     <= ny;
            err       <= ne;
            remaining <= remaining - ONE;
            pix_valid <= vis_next;
            pix_last  <= (remaining == ONE) && vis_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rast_line_stepper.sv
// Directed testbench for rast_line_stepper with hand-computed pixel sequences.
module tb_rast_line_stepper;
  import rast_pkg::*;

  localparam int CW = 10;
  localparam int AW = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [4*CW+AW-1:0]   line_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 abort;
  logic [CW-1:0]        pix_x;
  logic [CW-1:0]        pix_y;
  logic [AW-1:0]        pix_attr;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_last;
  octant_t              octant;
  logic                 line_done;
  logic                 busy;
  state_t               state_dbg;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  logic [AW-1:0] cur_attr;

  rast_line_stepper #(.COORD_W(CW), .ATTR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (line_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_attr  (pix_attr),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .octant    (octant),
    .line_done (line_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pix_word(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                           input logic last, input logic [AW-1:0] a);
    return {4'b0, 1'b1, x, y, last, a};
  endfunction

  function automatic logic [31:0] obs_word();
    return {4'b0, pix_valid, pix_x, pix_y, pix_last, pix_attr};
  endfunction

  task automatic push(input int x, input int y, input bit last);
    exp_q.push_back(pix_word(CW'(x), CW'(y), last, cur_attr));
  endtask

  // Presents one line for a single cycle; returns at the negedge of the SETUP cycle.
  task automatic send_line(input int x0, input int y0, input int x1, input int y1);
    @(negedge clk);
    line_in  = {CW'(x0), CW'(y0), CW'(x1), CW'(y1), cur_attr};
    in_valid = 1'b1;
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("setup_flags", {pix_valid, busy, in_ready}, 3'b010);
  endtask

  // mode 0: pix_ready held high; mode 1: pix_ready toggles 1/0 every cycle.
  task automatic run_line(input int mode, input int exp_n, input bit expect_last, input logic [2:0] exp_oct);
    int n = 0;
    int first = -1;
    int last_c = -1;
    int done_c = -1;
    bit held = 1'b0;
    logic [31:0] saved = '0;
    logic [31:0] obs;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (line_done) begin
        done_c = c;
        break;
      end
      obs = obs_word();
      if (held) check("hold_stable", obs, saved);
      if (c == 0) check("octant", octant, exp_oct);
      pix_ready = (mode == 0) || (c % 2 == 0);
      if (pix_valid && first < 0) first = c;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check("extra_pixel", obs, 32'hFFFF_FFFF);
        else check("pixel", obs, exp_q.pop_front());
        n++;
        if (pix_last) last_c = c;
      end
      held  = pix_valid && !pix_ready;
      saved = obs;
    end
    pix_ready = 1'b1;
    check("line_done_seen", done_c >= 0, 1);
    check("pixel_count", n, exp_n);
    if (exp_n > 0) check("first_valid_latency", first, 0);
    if (expect_last) check("done_after_last", done_c, last_c + 1);
    check("idle_after_line", {pix_valid, busy, in_ready}, 3'b001);
    exp_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    pix_ready = 1'b1;
    line_in   = '0;
    cur_attr  = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", {in_ready, pix_valid, pix_last, line_done, busy}, 5'b10000);
    check("reset_pixel", {pix_x, pix_y, pix_attr, octant}, '0);
    check("reset_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;

    // (0,0)->(4,2): shallow, positive octant
    cur_attr = 6'h15;
    push(0, 0, 0); push(1, 0, 0); push(2, 1, 0); push(3, 1, 0); push(4, 2, 1);
    send_line(0, 0, 4, 2);
    run_line(0, 5, 1, 3'b000);

    // (5,9)->(3,1): steep, both deltas negative
    cur_attr = 6'h2a;
    push(5, 9, 0); push(5, 8, 0); push(5, 7, 0); push(4, 6, 0); push(4, 5, 0);
    push(4, 4, 0); push(4, 3, 0); push(3, 2, 0); push(3, 1, 1);
    send_line(5, 9, 3, 1);
    run_line(0, 9, 1, 3'b111);

    // degenerate single-pixel line
    cur_attr = 6'h3f;
    push(7, 7, 1);
    send_line(7, 7, 7, 7);
    run_line(0, 1, 1, 3'b000);

    // (4,0)->(0,3): shallow, x decreasing
    cur_attr = 6'h0c;
    push(4, 0, 0); push(3, 1, 0); push(2, 1, 0); push(1, 2, 0); push(0, 3, 1);
    send_line(4, 0, 0, 3);
    run_line(0, 5, 1, 3'b010);

    // horizontal line with pix_ready toggling
    cur_attr = 6'h11;
    for (int i = 0; i <= 10; i++) push(i, 0, i == 10);
    send_line(0, 0, 10, 0);
    run_line(1, 11, 1, 3'b000);

    // abort on the 3rd pixel of (0,0)->(20,5); a second line offered while busy is ignored
    cur_attr = 6'h01;
    send_line(0, 0, 20, 5);
    @(negedge clk);
    check("abort_p0", obs_word(), pix_word(0, 0, 0, cur_attr));
    line_in  = {CW'(9), CW'(9), CW'(9), CW'(9), 6'h3c};
    in_valid = 1'b1;
    @(negedge clk);
    check("abort_p1", obs_word(), pix_word(1, 0, 0, cur_attr));
    check("busy_not_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_p2", obs_word(), pix_word(2, 0, 0, cur_attr));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done", {pix_valid, line_done, in_ready, busy}, 4'b0110);
    @(negedge clk);
    check("abort_pulse_end", {pix_valid, line_done, in_ready, busy}, 4'b0010);

    // a new line after the abort is accepted normally
    cur_attr = 6'h22;
    push(2, 3, 0); push(3, 3, 1);
    send_line(2, 3, 3, 3);
    run_line(0, 2, 1, 3'b000);

    // abort during SETUP, then abort while idle has no effect
    send_line(1, 1, 5, 5);
    abort = 1'b1;
    @(negedge clk);
    check("setup_abort", {pix_valid, line_done, in_ready, busy}, 4'b0110);
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ignored", {pix_valid, line_done, in_ready, busy, state_dbg}, {4'b0010, ST_IDLE});

    // reset in the middle of a line
    cur_attr = 6'h07;
    send_line(0, 0, 20, 5);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midline_reset", {pix_valid, line_done, in_ready, busy, pix_x, pix_y}, {4'b0010, 20'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_no_done", {line_done, state_dbg}, {1'b0, ST_IDLE});

`ifdef RAST_CLIP_EN
    // endpoint beyond the right edge: only x=630..639 are presented, no pix_last
    cur_attr = 6'h05;
    for (int i = 630; i < 640; i++) push(i, 0, 0);
    send_line(630, 0, 650, 0);
    run_line(0, 10, 0, 3'b000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
